// File: rtl/accum_buffer.sv
// Output-stationary partial-sum accumulator: one bank per crossbar lane, a 2-stage
// saturating in-place update, and a raster-order clear-on-read drain.
module accum_buffer #(
  parameter int unsigned NUM_DST = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned OUT_H   = 8,
  parameter int unsigned NUM_K   = 4,
  parameter int unsigned X_W     = $clog2(OUT_W),
  parameter int unsigned Y_W     = $clog2(OUT_H),
  parameter int unsigned K_W     = $clog2(NUM_K)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_DST-1:0]        in_valid,
  input  logic [NUM_DST*DATA_W-1:0] in_data,
  input  logic [NUM_DST*X_W-1:0]    in_x,
  input  logic [NUM_DST*Y_W-1:0]    in_y,
  input  logic [NUM_DST*K_W-1:0]    in_k,
  output logic                      busy,
  input  logic                      drain_start,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_data,
  output logic [X_W-1:0]            out_x,
  output logic [Y_W-1:0]            out_y,
  output logic [K_W-1:0]            out_k,
  output logic                      drain_done,
  output logic                      err_drop
);

  localparam int unsigned DEPTH  = (OUT_H / NUM_DST) * OUT_W * NUM_K;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BANK_W = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;

  typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN, DONE} state_t;

  state_t state;

  logic signed [ACC_W-1:0] mem [NUM_DST][DEPTH];

  logic                    s1_valid [NUM_DST];
  logic [ADDR_W-1:0]       s1_addr  [NUM_DST];
  logic signed [ACC_W-1:0] s1_data  [NUM_DST];

  logic [X_W-1:0]    lane_x    [NUM_DST];
  logic [Y_W-1:0]    lane_y    [NUM_DST];
  logic [K_W-1:0]    lane_k    [NUM_DST];
  logic              lane_ok   [NUM_DST];
  logic [ADDR_W-1:0] lane_addr [NUM_DST];

  logic [BANK_W-1:0] drain_bank;
  logic [ADDR_W-1:0] drain_addr;
  logic              last_word;

  // Bank-local address: each bank holds every NUM_DST-th row.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [X_W-1:0] x,
                                                input logic [Y_W-1:0] y,
                                                input logic [K_W-1:0] k);
    addr_of = ADDR_W'(((32'(y) / NUM_DST) * OUT_W + 32'(x)) * NUM_K + 32'(k));
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                     input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] sum;
    sum = (ACC_W+1)'(a) + (ACC_W+1)'(b);
    if (sum[ACC_W] != sum[ACC_W-1])
      sat_add = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_add = sum[ACC_W-1:0];
  endfunction

  // Per-lane unpack and legality: range, lane ownership, and not busy.
  always_comb begin
    for (int l = 0; l < NUM_DST; l++) begin
      lane_x[l]    = in_x[l*X_W +: X_W];
      lane_y[l]    = in_y[l*Y_W +: Y_W];
      lane_k[l]    = in_k[l*K_W +: K_W];
      lane_ok[l]   = (32'(lane_x[l]) < OUT_W) && (32'(lane_y[l]) < OUT_H) &&
                     (32'(lane_k[l]) < NUM_K) &&
                     (32'(lane_y[l]) % NUM_DST == 32'(l)) && !busy;
      lane_addr[l] = addr_of(lane_x[l], lane_y[l], lane_k[l]);
    end
  end

  assign drain_bank = BANK_W'(32'(out_y) % NUM_DST);
  assign drain_addr = addr_of(out_x, out_y, out_k);
  assign last_word  = (out_y == Y_W'(OUT_H-1)) && (out_x == X_W'(OUT_W-1)) &&
                      (out_k == K_W'(NUM_K-1));
  assign out_data   = (state == DRAIN) ? mem[drain_bank][drain_addr] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ACCUM;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      drain_done <= 1'b0;
      err_drop   <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_k      <= '0;
      for (int l = 0; l < NUM_DST; l++) begin
        s1_valid[l] <= 1'b0;
        s1_addr[l]  <= '0;
        s1_data[l]  <= '0;
        for (int unsigned a = 0; a < DEPTH; a++) mem[l][a] <= '0;
      end
    end else begin
      drain_done <= 1'b0;

      // Stage 1 captures legal inputs; stage 2 accumulates into the bank.
      for (int l = 0; l < NUM_DST; l++) begin
        s1_valid[l] <= in_valid[l] && lane_ok[l];
        s1_addr[l]  <= lane_addr[l];
        s1_data[l]  <= ACC_W'($signed(in_data[l*DATA_W +: DATA_W]));
        if (in_valid[l] && !lane_ok[l]) err_drop <= 1'b1;
        if (s1_valid[l]) mem[l][s1_addr[l]] <= sat_add(mem[l][s1_addr[l]], s1_data[l]);
      end

      case (state)
        ACCUM: begin
          if (drain_start) begin
            state <= FLUSH;
            busy  <= 1'b1;
          end
        end
        FLUSH: begin
          state     <= DRAIN;
          out_valid <= 1'b1;
          out_x     <= '0;
          out_y     <= '0;
          out_k     <= '0;
        end
        DRAIN: begin
          if (out_ready) begin
            mem[drain_bank][drain_addr] <= '0;
            if (last_word) begin
              state      <= DONE;
              out_valid  <= 1'b0;
              drain_done <= 1'b1;
            end else if (out_k == K_W'(NUM_K-1)) begin
              out_k <= '0;
              if (out_x == X_W'(OUT_W-1)) begin
                out_x <= '0;
                out_y <= out_y + Y_W'(1);
              end else begin
                out_x <= out_x + X_W'(1);
              end
            end else begin
              out_k <= out_k + K_W'(1);
            end
          end
        end
        DONE: begin
          state <= ACCUM;
          busy  <= 1'b0;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_buffer.sv
// Scoreboard bench for accum_buffer: an image model feeds an expected-word queue that
// is checked against every drain handshake.
module tb_accum_buffer;

  localparam int unsigned NUM_DST = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ACC_W   = 24;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned OUT_H   = 8;
  localparam int unsigned NUM_K   = 4;
  localparam int unsigned X_W     = 3;
  localparam int unsigned Y_W     = 3;
  localparam int unsigned K_W     = 2;
  localparam int unsigned WORDS   = OUT_H * OUT_W * NUM_K;
  localparam int          ACC_MAX = 8388607;
  localparam int          ACC_MIN = -8388608;

  logic                      clock;
  logic                      reset;
  logic [NUM_DST-1:0]        in_valid;
  logic [NUM_DST*DATA_W-1:0] in_data;
  logic [NUM_DST*X_W-1:0]    in_x;
  logic [NUM_DST*Y_W-1:0]    in_y;
  logic [NUM_DST*K_W-1:0]    in_k;
  logic                      busy;
  logic                      drain_start;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [ACC_W-1:0]   out_data;
  logic [X_W-1:0]            out_x;
  logic [Y_W-1:0]            out_y;
  logic [K_W-1:0]            out_k;
  logic                      drain_done;
  logic                      err_drop;

  accum_buffer #(
    .NUM_DST(NUM_DST), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
    .OUT_H(OUT_H), .NUM_K(NUM_K), .X_W(X_W), .Y_W(Y_W), .K_W(K_W)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_x(in_x), .in_y(in_y), .in_k(in_k), .busy(busy), .drain_start(drain_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_k(out_k), .drain_done(drain_done),
    .err_drop(err_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int y;
    int x;
    int k;
    int d;
  } word_t;

  word_t exp_q[$];
  int    img [WORDS];
  int    cap [WORDS];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    word_total = 0;
  int    done_total = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int idx(input int x, input int y, input int k);
    return (y * OUT_W + x) * NUM_K + k;
  endfunction

  function automatic int sat_acc(input int a, input int b);
    int s;
    s = a + b;
    if (s > ACC_MAX) return ACC_MAX;
    if (s < ACC_MIN) return ACC_MIN;
    return s;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    in_valid = '0;
  endtask

  // Drive one lane for the coming edge; legal inputs update the model image.
  task automatic put(input int l, input int x, input int y, input int k, input int d,
                     input bit ok);
    in_valid[l]                = 1'b1;
    in_x[l*X_W +: X_W]         = X_W'(x);
    in_y[l*Y_W +: Y_W]         = Y_W'(y);
    in_k[l*K_W +: K_W]         = K_W'(k);
    in_data[l*DATA_W +: DATA_W] = DATA_W'(d);
    if (ok) img[idx(x, y, k)] = sat_acc(img[idx(x, y, k)], d);
  endtask

  task automatic push_image();
    for (int y = 0; y < OUT_H; y++)
      for (int x = 0; x < OUT_W; x++)
        for (int k = 0; k < NUM_K; k++) begin
          exp_q.push_back('{y, x, k, img[idx(x, y, k)]});
          img[idx(x, y, k)] = 0;
        end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    drain_start = 1'b0;
    out_ready   = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < WORDS; i++) img[i] = 0;
  endtask

  // Full drain; toggle halves out_ready, inj drives an input while busy.
  task automatic run_drain(input string tag, input bit toggle, input bit inj);
    int base_w;
    int base_d;
    int c;
    push_image();
    base_w = word_total;
    base_d = done_total;
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    if (inj) begin
      check({tag, "_busy_high"}, busy, 1);
      put(1, 0, 1, 0, 9, 1'b0);
    end
    c = 0;
    while (done_total == base_d && c < 2000) begin
      out_ready = toggle ? c[0] : 1'b1;
      tick();
      c++;
    end
    out_ready = 1'b1;
    check({tag, "_done_seen"}, done_total - base_d, 1);
    check({tag, "_word_count"}, word_total - base_w, WORDS);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_valid_after"}, out_valid, 0);
    if (inj) check({tag, "_err_drop"}, err_drop, 1);
  endtask

  function automatic int count_nonzero();
    int n;
    n = 0;
    for (int i = 0; i < WORDS; i++) if (cap[i] != 0) n++;
    return n;
  endfunction

  // Monitor: score handshakes, capture words, check hold-stability under backpressure.
  logic            hold_pending = 1'b0;
  logic [X_W-1:0]  hold_x;
  logic [Y_W-1:0]  hold_y;
  logic [K_W-1:0]  hold_k;
  logic [ACC_W-1:0] hold_d;
  always @(negedge clock) begin
    word_t w;
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && out_valid) begin
        check("hold_data", out_data, $signed(hold_d));
        check("hold_xyk", {out_y, out_x, out_k}, {hold_y, hold_x, hold_k});
      end
      hold_pending = 1'b0;
      if (out_valid && !out_ready) begin
        hold_pending = 1'b1;
        hold_x = out_x;
        hold_y = out_y;
        hold_k = out_k;
        hold_d = out_data;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          w = exp_q.pop_front();
          check("word_data", out_data, w.d);
          check("word_y", out_y, w.y);
          check("word_x", out_x, w.x);
          check("word_k", out_k, w.k);
        end
        cap[idx(int'(out_x), int'(out_y), int'(out_k))] = int'(out_data);
        word_total++;
      end
      if (drain_done) done_total++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_w;
    int base_d;
    int c;
    reset = 1'b1; in_valid = '0; in_data = '0; in_x = '0; in_y = '0; in_k = '0;
    drain_start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < WORDS; i++) begin img[i] = 0; cap[i] = 0; end
    repeat (3) tick();
    reset = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drain_done", drain_done, 0);
    check("rst_err_drop", err_drop, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_xyk", {out_y, out_x, out_k}, 0);

    // Single entry accumulated three times, then clear-on-read.
    repeat (3) begin put(1, 3, 5, 2, 100, 1'b1); tick(); end
    run_drain("basic", 1'b0, 1'b0);
    check("basic_word_5_3_2", cap[idx(3, 5, 2)], 300);
    check("basic_nonzero", count_nonzero(), 1);
    check("basic_err_drop", err_drop, 0);
    run_drain("cleared", 1'b0, 1'b0);
    check("cleared_nonzero", count_nonzero(), 0);

    // All lanes at once, in the same cycle as drain_start.
    for (int l = 0; l < NUM_DST; l++) put(l, 0, l, 0, l + 1, 1'b1);
    run_drain("lanes", 1'b0, 1'b0);
    for (int l = 0; l < NUM_DST; l++) check("lanes_word", cap[idx(0, l, 0)], l + 1);

    // Saturation at both rails with back-to-back updates.
    for (int c2 = 0; c2 < 600; c2++) begin
      if (c2 < 300) put(0, 1, 0, 0, 32767, 1'b1);
      put(2, 2, 2, 1, -32768, 1'b1);
      tick();
    end
    run_drain("sat", 1'b0, 1'b0);
    check("sat_pos", cap[idx(1, 0, 0)], ACC_MAX);
    check("sat_neg", cap[idx(2, 2, 1)], ACC_MIN);

    // Drop while busy.
    do_reset();
    put(1, 2, 1, 1, -7, 1'b1);
    tick();
    run_drain("busy_drop", 1'b0, 1'b1);
    check("busy_drop_kept", cap[idx(2, 1, 1)], -7);
    check("busy_drop_absent", cap[idx(0, 1, 0)], 0);

    // Drop on wrong lane.
    do_reset();
    put(1, 2, 1, 1, -7, 1'b1);
    put(0, 4, 1, 1, 55, 1'b0);
    tick();
    check("lane_drop_err", err_drop, 1);
    run_drain("lane_drop", 1'b0, 1'b0);
    check("lane_drop_absent", cap[idx(4, 1, 1)], 0);

    // All-ones row presented on lane 0 is dropped; same coords on lane 3 are kept.
    do_reset();
    check("ones_err_clear", err_drop, 0);
    put(0, 5, 7, 3, 77, 1'b0);
    put(3, 5, 7, 3, 11, 1'b1);
    tick();
    check("ones_drop_err", err_drop, 1);
    run_drain("ones_drop", 1'b0, 1'b0);
    check("ones_drop_word", cap[idx(5, 7, 3)], 11);

    // Backpressure with out_ready toggling.
    put(3, 7, 7, 3, -5, 1'b1);
    put(0, 0, 0, 0, 1234, 1'b1);
    tick();
    run_drain("bp", 1'b1, 1'b0);
    check("bp_first", cap[idx(0, 0, 0)], 1234);
    check("bp_last", cap[idx(7, 7, 3)], -5);

    // Reset mid-drain aborts without drain_done and clears everything.
    put(2, 1, 6, 0, 42, 1'b1);
    tick();
    push_image();
    base_w = word_total;
    base_d = done_total;
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    c = 0;
    while (word_total - base_w < 40 && c < 200) begin tick(); c++; end
    check("abort_reached_40", (word_total - base_w >= 40) ? 1 : 0, 1);
    reset = 1'b1;
    tick();
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < WORDS; i++) img[i] = 0;
    repeat (5) begin
      tick();
      check("abort_no_done", drain_done, 0);
    end
    check("abort_done_count", done_total - base_d, 0);
    run_drain("after_abort", 1'b0, 1'b0);
    check("after_abort_nonzero", count_nonzero(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
